// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_STRETCH    = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_STAGGER    = 2'd2,
    ST_RUN        = 2'd3
  } rst_seq_state_t;

  localparam int RST_SEQ_MAX_DOMAINS = 8;
  localparam int RST_SEQ_IDX_W       = $clog2(RST_SEQ_MAX_DOMAINS);

  // Largest of three cycle counts; sizes the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches the system reset, then releases NUM_DOMAINS
// reset domains one at a time, waiting for each to report ready (or time
// out) and inserting a stagger gap before the next. RUN accepts a software
// reset request that restarts the whole sequence.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int STRETCH_CYCLES = 128,
  parameter int STAGGER_CYCLES = 4,
  parameter int READY_TIMEOUT  = 1024
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   i_sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] i_domain_ready,
  output logic [NUM_DOMAINS-1:0] o_rst,
  output logic                   o_busy,
  output logic [NUM_DOMAINS-1:0] o_timeout_err,
  output logic [1:0]             o_state
);

  localparam int CNT_MAX = max3(STRETCH_CYCLES, READY_TIMEOUT, STAGGER_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STG_LAST_I = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0]         STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]         TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]         STAGGER_LAST = CNT_W'(STG_LAST_I);
  localparam logic [RST_SEQ_IDX_W-1:0] LAST_IDX     = RST_SEQ_IDX_W'(NUM_DOMAINS - 1);

  rst_seq_state_t             state;
  logic [CNT_W-1:0]           cnt;
  logic [RST_SEQ_IDX_W-1:0]   idx;
  logic [NUM_DOMAINS-1:0]     cur_mask;
  logic [NUM_DOMAINS-1:0]     nxt_mask;
  logic                       rdy_sel;

  assign o_state = state;

  // Decode the current domain index: its ready bit, its own mask and the
  // mask of the domain released next. Only the released domain is sampled.
  always_comb begin
    cur_mask = '0;
    nxt_mask = '0;
    rdy_sel  = 1'b0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      if (idx == RST_SEQ_IDX_W'(d)) begin
        cur_mask[d] = 1'b1;
        rdy_sel     = i_domain_ready[d];
      end
      if (idx + RST_SEQ_IDX_W'(1) == RST_SEQ_IDX_W'(d)) nxt_mask[d] = 1'b1;
    end
  end

  // Sequencer FSM with registered outputs; synchronous reset wins everywhere.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_STRETCH;
      cnt           <= '0;
      idx           <= '0;
      o_rst         <= '1;
      o_busy        <= 1'b1;
      o_timeout_err <= '0;
    end else begin
      case (state)
        ST_STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            o_rst[0] <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            state    <= ST_WAIT_READY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_READY: begin
          if (rdy_sel || cnt == TIMEOUT_LAST) begin
            // A timeout still counts as done so bring-up never stalls.
            if (!rdy_sel) o_timeout_err <= o_timeout_err | cur_mask;
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state  <= ST_RUN;
              o_busy <= 1'b0;
            end else if (STAGGER_CYCLES == 0) begin
              o_rst <= o_rst & ~nxt_mask;
              idx   <= idx + 1'b1;
            end else begin
              state <= ST_STAGGER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STAGGER: begin
          if (cnt == STAGGER_LAST) begin
            o_rst <= o_rst & ~nxt_mask;
            idx   <= idx + 1'b1;
            cnt   <= '0;
            state <= ST_WAIT_READY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Software reset restarts the full sequence; timeout flags persist.
          if (i_sw_rst_req) begin
            o_rst  <= '1;
            o_busy <= 1'b1;
            cnt    <= '0;
            idx    <= '0;
            state  <= ST_STRETCH;
          end
        end
        default: state <= ST_STRETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: four instances cover the default
// sequence, a ready timeout plus software/hardware reset, zero stagger,
// and a single-domain minimum stretch.
module tb_reset_sequencer;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // A: defaults
  logic       rstn_a, req_a;
  logic [2:0] rdy_a, rst_a, err_a;
  logic       busy_a;
  logic [1:0] st_a;
  // B: READY_TIMEOUT=16, domain 1 never ready
  logic       rstn_b, req_b;
  logic [2:0] rdy_b, rst_b, err_b;
  logic       busy_b;
  logic [1:0] st_b;
  // C: STAGGER_CYCLES=0, all ready
  logic       rstn_c, req_c;
  logic [2:0] rdy_c, rst_c, err_c;
  logic       busy_c;
  logic [1:0] st_c;
  // D: one domain, STRETCH_CYCLES=1
  logic       rstn_d, req_d, rdy_d, rst_d, err_d, busy_d;
  logic [1:0] st_d;

  int age_a[3];
  int age_b[3];

  reset_sequencer u_a (
    .aclk(aclk), .aresetn(rstn_a), .i_sw_rst_req(req_a), .i_domain_ready(rdy_a),
    .o_rst(rst_a), .o_busy(busy_a), .o_timeout_err(err_a), .o_state(st_a));

  reset_sequencer #(.READY_TIMEOUT(16)) u_b (
    .aclk(aclk), .aresetn(rstn_b), .i_sw_rst_req(req_b), .i_domain_ready(rdy_b),
    .o_rst(rst_b), .o_busy(busy_b), .o_timeout_err(err_b), .o_state(st_b));

  reset_sequencer #(.STAGGER_CYCLES(0)) u_c (
    .aclk(aclk), .aresetn(rstn_c), .i_sw_rst_req(req_c), .i_domain_ready(rdy_c),
    .o_rst(rst_c), .o_busy(busy_c), .o_timeout_err(err_c), .o_state(st_c));

  reset_sequencer #(.NUM_DOMAINS(1), .STRETCH_CYCLES(1)) u_d (
    .aclk(aclk), .aresetn(rstn_d), .i_sw_rst_req(req_d), .i_domain_ready(rdy_d),
    .o_rst(rst_d), .o_busy(busy_d), .o_timeout_err(err_d), .o_state(st_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ready model: a domain reports ready 3 edges after its reset falls,
  // so the sequencer first sees it on the 4th edge. Domain 1 of B never does.
  task automatic upd_ready();
    for (int i = 0; i < 3; i++) begin
      if (rst_a[i]) age_a[i] = 0; else age_a[i]++;
      if (rst_b[i]) age_b[i] = 0; else age_b[i]++;
      rdy_a[i] = (age_a[i] >= 4);
      rdy_b[i] = (age_b[i] >= 4) && (i != 1);
    end
  endtask

  // One clock edge; sample 1 time unit later, then update ready inputs.
  task automatic tick();
    @(posedge aclk);
    #1;
    upd_ready();
  endtask

  initial begin
    rstn_a = 0; rstn_b = 0; rstn_c = 0; rstn_d = 0;
    req_a = 0; req_b = 0; req_c = 0; req_d = 1;
    rdy_a = '0; rdy_b = '0; rdy_c = 3'b111; rdy_d = 1'b1;
    for (int i = 0; i < 3; i++) begin age_a[i] = 0; age_b[i] = 0; end

    for (int i = 0; i < 5; i++) tick();
    chk("rst_a_rst",  rst_a,  3'b111);
    chk("rst_busy_a", busy_a, 1);
    chk("rst_err_a",  err_a,  0);
    chk("rst_st_a",   st_a,   0);
    chk("rst_d_rst",  rst_d,  1);

    rstn_a = 1; rstn_b = 1; rstn_c = 1; rstn_d = 1;

    for (int e = 1; e <= 165; e++) begin
      tick();
      // A: default sequence
      case (e)
        127: chk("a_hold127", rst_a, 3'b111);
        128: begin chk("a_rel0", rst_a, 3'b110); chk("a_st128", st_a, 1); end
        139: chk("a_wait139", st_a, 1);
        140: chk("a_stg140", st_a, 2);
        135: begin chk("a_hold135", rst_a, 3'b110); chk("a_st135", st_a, 2); end
        136: begin chk("a_rel1", rst_a, 3'b100); chk("a_st136", st_a, 1); end
        143: chk("a_hold143", rst_a, 3'b100);
        144: chk("a_rel2", rst_a, 3'b000);
        147: chk("a_busy147", busy_a, 1);
        148: begin chk("a_busy148", busy_a, 0); chk("a_run", st_a, 3); chk("a_err", err_a, 0); end
        default: ;
      endcase
      // B: domain 1 times out after 16 edges in WAIT_READY
      case (e)
        136: chk("b_rel1", rst_b, 3'b100);
        151: begin chk("b_err151", err_b, 0); chk("b_st151", st_b, 1); end
        152: begin chk("b_err152", err_b, 3'b010); chk("b_st152", st_b, 2); end
        155: chk("b_hold155", rst_b, 3'b100);
        156: begin chk("b_rel2", rst_b, 3'b000); chk("b_st156", st_b, 1); end
        159: chk("b_busy159", busy_b, 1);
        160: begin chk("b_run", st_b, 3); chk("b_busy160", busy_b, 0); end
        default: ;
      endcase
      // C: zero stagger; ready[2] is only sampled once its reset is released
      case (e)
        127: chk("c_hold127", rst_c, 3'b111);
        128: chk("c_rel0", rst_c, 3'b110);
        129: chk("c_rel1", rst_c, 3'b100);
        130: begin chk("c_rel2", rst_c, 3'b000); chk("c_busy130", busy_c, 1); chk("c_st130", st_c, 1); end
        131: begin chk("c_run", st_c, 3); chk("c_busy131", busy_c, 0); end
        default: ;
      endcase
      // D: software request held through STRETCH only acts in RUN
      case (e)
        1: begin chk("d_rel", rst_d, 0); chk("d_st1", st_d, 1); end
        2: begin chk("d_run", st_d, 3); chk("d_busy2", busy_d, 0); end
        3: begin chk("d_swrst", rst_d, 1); chk("d_st3", st_d, 0); chk("d_busy3", busy_d, 1); req_d = 0; end
        4: chk("d_rel2", rst_d, 0);
        5: chk("d_run2", st_d, 3);
        default: ;
      endcase
    end

    // B: one-cycle software reset from RUN; timeout flag must survive it
    req_b = 1;
    tick();
    req_b = 0;
    chk("b_sw_rst",  rst_b,  3'b111);
    chk("b_sw_busy", busy_b, 1);
    chk("b_sw_st",   st_b,   0);
    chk("b_sw_err",  err_b,  3'b010);
    for (int i = 0; i < 127; i++) tick();
    chk("b_sw_hold", rst_b, 3'b111);
    tick();
    chk("b_sw_rel0", rst_b, 3'b110);
    for (int i = 0; i < 4; i++) tick();
    chk("b_sw_stg", st_b, 2);
    chk("b_sw_err2", err_b, 3'b010);

    // B: hardware reset during STAGGER clears everything including errors
    rstn_b = 0;
    tick();
    chk("b_hw_rst",  rst_b,  3'b111);
    chk("b_hw_st",   st_b,   0);
    chk("b_hw_err",  err_b,  0);
    chk("b_hw_busy", busy_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
